regfile_scoreboard: RTL
=======================

Name: regfile_scoreboard

Overview:
- Parametrised integer register file for the pipelined RV32I core.
- Provides NRD combinational read ports, one write-back port and a per-register pending-write scoreboard.
- Adds optional write-back-to-read bypass for the decode stage.
- Sits between decode/issue (reads, marks destinations busy) and write-back (commits, clears busy). x0 is hardwired to zero.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers (power of two, >=2); AW = $clog2(NREGS).
- NRD, 2, number of read ports.
- BYPASS, 1, 1 = a same-cycle write-back is forwarded to matching read ports; 0 = reads see only committed state.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all registers, scoreboard and error flag.
- rs_addr  in  NRD*AW  packed read addresses, port i at [i*AW +: AW].
- rs_data  out  NRD*XLEN  packed read data, port i at [i*XLEN +: XLEN].
- rs_busy  out  NRD  port i address has a pending (uncommitted) write.
- issue_valid  in  1  issue stage requests to mark issue_rd pending.
- issue_rd  in  AW  destination register of issuing instruction.
- issue_ready  out  1  issue accepted this cycle when issue_valid && issue_ready.
- wb_valid  in  1  write-back strobe.
- wb_rd  in  AW  write-back destination.
- wb_data  in  XLEN  write-back data.
- last_wb  out  XLEN  registered copy of the most recent committed write-back data (debug observation).
- err_wb_unexp  out  1  sticky: write-back to a register that was not pending.

Behaviour:
- Reset (clk edge with reset=1):
  - All registers = 0, busy[] = 0, last_wb = 0, err_wb_unexp = 0.
  - reset overrides issue and write-back in the same cycle.
- Storage: reg[0] is never written; reads of address 0 return 0 with rs_busy = 0 on every port.
- Read: combinational, zero latency. rs_data[i] = reg[rs_addr[i]], except:
  - If BYPASS=1 && wb_valid && wb_rd==rs_addr[i] && rs_addr[i]!=0, then rs_data[i] = wb_data.
- rs_busy[i]:
  - BYPASS=1: busy[a] && !(wb_valid && wb_rd==a), where a = rs_addr[i].
  - BYPASS=0: busy[a].
  - Forced to 0 when a==0.
- Write-back (edge, wb_valid, wb_rd!=0):
  - reg[wb_rd] <= wb_data; busy[wb_rd] <= 0; last_wb <= wb_data.
  - If busy[wb_rd] was 0, err_wb_unexp <= 1 (data is still written).
  - wb_rd==0: no register or busy change; last_wb still updates; no error.
- issue_ready = !busy[issue_rd] || (wb_valid && wb_rd==issue_rd) || issue_rd==0. This blocks WAW hazards and issue_ready is combinational.
- Issue accept (issue_valid && issue_ready, issue_rd!=0): busy[issue_rd] <= 1.
- Simultaneous write-back and issue to the same rd: the data is written and busy ends at 1 (issue wins the busy bit).
- Issue to rd 0 is accepted and leaves no state change.
- Multiple read ports at the same address return identical data and busy.
- Reset asserted mid-stream discards all pending marks. A later write-back to a now-clear register sets err_wb_unexp.

Decomposition:
- Package regfile_pkg holds:
  - Default XLEN and NREGS localparams.
  - The AW derivation via $clog2.
  - A typedef for the register word (logic [XLEN-1:0]).
- Sub-module rf_scoreboard (busy vector, issue_ready, busy-clear and error logic) is natural; storage, read muxes and bypass stay in the top module.

Test Plan:
- Reset then read x0..x31 on both ports -> all data 0, rs_busy=00, issue_ready=1, err=0.
- Issue x5, next cycle wb x5=32'hDEADBEEF while rs_addr0=5 -> same cycle rs_data0=DEADBEEF, rs_busy0=0 (BYPASS=1). The following cycle has the same result from storage, and last_wb=DEADBEEF.
- Issue x7; issue x7 again -> issue_ready=0. Then the same cycle has wb x7=1 with issue x7 -> accepted; x7 reads 1 and busy stays 1.
- wb x0=32'h1234 -> x0 reads 0, last_wb=1234, err=0. wb x3 with x3 not pending -> x3 updated, err_wb_unexp=1 and stays 1.
- Issue x9, assert reset for one cycle, then wb x9=5 -> after reset busy clear, x9=0; after wb x9=5 and err=1.
- BYPASS=0 build: wb x4=8 with rs_addr1=4 -> same cycle old value and rs_busy1 unchanged; next cycle 8.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and types for the RV32I integer register file.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [XLEN_DEF-1:0] word_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register.
// Issue sets the bit, write-back clears it. A write-back to a register
// that is not pending raises a sticky error flag.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NRD*AW-1:0] rs_addr,
    output logic [NRD-1:0]    rs_busy,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_rd,
    output logic              issue_ready,
    input  logic              wb_valid,
    input  logic [AW-1:0]     wb_rd,
    output logic              err_wb_unexp
);

    logic [NREGS-1:0] busy;
    logic             wb_hits_issue;
    logic             issue_fire;

    // A write-back landing this cycle frees its register, so an issue
    // to that register does not have to wait.
    assign wb_hits_issue = wb_valid && (wb_rd == issue_rd);
    assign issue_ready   = !busy[issue_rd] || wb_hits_issue || (issue_rd == '0);
    assign issue_fire    = issue_valid && issue_ready && (issue_rd != '0);

    // Per-port busy view; a matching write-back hides the pending mark
    // when bypassing, because the data is already on the read port.
    for (genvar g = 0; g < NRD; g++) begin : g_busy
        logic [AW-1:0] a;
        logic          wb_hit;
        assign a          = rs_addr[g*AW +: AW];
        assign wb_hit     = (BYPASS != 0) && wb_valid && (wb_rd == a);
        assign rs_busy[g] = (a != '0) && busy[a] && !wb_hit;
    end

    // Busy bits and error flag. The issue set is ordered after the
    // write-back clear so a same-cycle issue to the same rd keeps it busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy         <= '0;
            err_wb_unexp <= 1'b0;
        end else begin
            if (wb_valid && (wb_rd != '0)) begin
                busy[wb_rd] <= 1'b0;
                if (!busy[wb_rd]) begin
                    err_wb_unexp <= 1'b1;
                end
            end
            if (issue_fire) begin
                busy[issue_rd] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with NRD combinational read ports, one write-back
// port, optional write-back-to-read bypass and a pending-write scoreboard.
// x0 reads as zero and is never written.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_busy,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    output logic                issue_ready,
    input  logic                wb_valid,
    input  logic [AW-1:0]       wb_rd,
    input  logic [XLEN-1:0]     wb_data,
    output logic [XLEN-1:0]     last_wb,
    output logic                err_wb_unexp
);

    logic [XLEN-1:0] regs [NREGS];

    // Register storage and debug copy of the last write-back; x0 is
    // skipped on write so it stays zero from reset onward.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
            last_wb <= '0;
        end else if (wb_valid) begin
            last_wb <= wb_data;
            if (wb_rd != '0) begin
                regs[wb_rd] <= wb_data;
            end
        end
    end

    // Read muxes with same-cycle write-back forwarding.
    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0] a;
        logic          wb_hit;
        assign a      = rs_addr[g*AW +: AW];
        assign wb_hit = (BYPASS != 0) && wb_valid && (wb_rd == a);
        assign rs_data[g*XLEN +: XLEN] = (a == '0) ? '0 :
                                         wb_hit    ? wb_data : regs[a];
    end

    rf_scoreboard #(
        .NREGS  (NREGS),
        .NRD    (NRD),
        .BYPASS (BYPASS)
    ) u_sb (
        .clk          (clk),
        .reset        (reset),
        .rs_addr      (rs_addr),
        .rs_busy      (rs_busy),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_ready  (issue_ready),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .err_wb_unexp (err_wb_unexp)
    );

endmodule
